// File: rtl/conv1d_ctrl.sv
// conv1d accelerator sequencer: loads kernel taps, then walks the input window by window
// over a single-outstanding memory port, driving an external MAC. Optional macro: CONV1D_CTRL_PERF_EN.
module conv1d_ctrl #(
  parameter int MAX_K  = 8,
  parameter int LEN_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [31:0]                  in_addr_i,
  input  logic [31:0]                  w_addr_i,
  input  logic [31:0]                  out_addr_i,
  input  logic [LEN_W-1:0]             in_len_i,
  input  logic [$clog2(MAX_K+1)-1:0]   k_len_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic                         done_int_o,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  output logic                         mem_we_o,
  output logic [31:0]                  mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  output logic                         mac_clr_o,
  output logic                         mac_en_o,
  output logic [DATA_W-1:0]            mac_x_o,
  output logic [DATA_W-1:0]            mac_w_o,
  input  logic [DATA_W-1:0]            mac_acc_i,
  output logic [31:0]                  perf_cycles_o
);

  localparam int IW = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_CLR, S_RD_X, S_MAC, S_ACC_WAIT, S_WR_Y, S_DONE
  } state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IW-1:0] idx);
    return base + (32'(idx) << 5'd2);
  endfunction

  state_t              state_q, state_d;
  logic [31:0]         in_addr_q, in_addr_d, w_addr_q, w_addr_d, out_addr_q, out_addr_d;
  logic [IW-1:0]       k_len_q, k_len_d, m_q, m_d, i_q, i_d, k_q, k_d;
  logic [DATA_W-1:0]   tap_q [MAX_K];
  logic [DATA_W-1:0]   tap_d [MAX_K];
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d, done_int_q, done_int_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d, wait_q, wait_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mac_clr_q, mac_clr_d, mac_en_q, mac_en_d;
  logic [DATA_W-1:0]   mac_x_q, mac_x_d, mac_w_q, mac_w_d;

  logic                rsp_s, cfg_bad_s;
  logic [IW-1:0]       k_in_s, n_in_s, k_inc_s, i_inc_s, ik_s;
  logic [DATA_W-1:0]   tap_sel_s;

  assign rsp_s     = wait_q && mem_rvalid_i;
  assign k_in_s    = IW'(k_len_i);
  assign n_in_s    = IW'(in_len_i);
  assign cfg_bad_s = (k_in_s == IW'(0)) || (k_in_s > IW'(MAX_K)) || (n_in_s < k_in_s);
  assign k_inc_s   = k_q + IW'(1);
  assign i_inc_s   = i_q + IW'(1);
  assign ik_s      = i_q + k_q;

  // Tap operand selected by the current kernel index
  always_comb begin
    tap_sel_s = {DATA_W{1'b0}};
    for (int j = 0; j < MAX_K; j++) begin
      if (k_q == IW'(j)) begin
        tap_sel_s = tap_q[j];
      end else begin
        tap_sel_s = tap_sel_s;
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    in_addr_d   = in_addr_q;
    w_addr_d    = w_addr_q;
    out_addr_d  = out_addr_q;
    k_len_d     = k_len_q;
    m_d         = m_q;
    i_d         = i_q;
    k_d         = k_q;
    tap_d       = tap_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    done_int_d  = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wait_d      = wait_q;
    mac_clr_d   = 1'b0;
    mac_en_d    = 1'b0;
    mac_x_d     = mac_x_q;
    mac_w_d     = mac_w_q;

    // Request retires on grant; the response is awaited separately
    if (mem_req_q && mem_gnt_i) begin
      mem_req_d = 1'b0;
      wait_d    = 1'b1;
    end else begin
      mem_req_d = mem_req_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          in_addr_d  = in_addr_i;
          w_addr_d   = w_addr_i;
          out_addr_d = out_addr_i;
          k_len_d    = k_in_s;
          m_d        = n_in_s - k_in_s + IW'(1);
          done_d     = 1'b0;
          err_d      = 1'b0;
          if (cfg_bad_s) begin
            err_d      = 1'b1;
            done_d     = 1'b1;
            done_int_d = 1'b1;
          end else begin
            busy_d     = 1'b1;
            state_d    = S_LOAD_W;
            k_d        = IW'(0);
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = w_addr_i;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (rsp_s) begin
          wait_d = 1'b0;
          for (int j = 0; j < MAX_K; j++) begin
            if (k_q == IW'(j)) begin
              tap_d[j] = mem_rdata_i;
            end else begin
              tap_d[j] = tap_q[j];
            end
          end
          k_d = k_inc_s;
          if (k_inc_s < k_len_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = word_addr(w_addr_q, k_inc_s);
          end else begin
            state_d   = S_CLR;
            mac_clr_d = 1'b1;
            i_d       = IW'(0);
            k_d       = IW'(0);
          end
        end else begin
          state_d = S_LOAD_W;
        end
      end
      S_CLR: begin
        state_d    = S_RD_X;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = word_addr(in_addr_q, ik_s);
      end
      S_RD_X: begin
        if (rsp_s) begin
          wait_d   = 1'b0;
          mac_en_d = 1'b1;
          mac_x_d  = mem_rdata_i;
          mac_w_d  = tap_sel_s;
          k_d      = k_inc_s;
          state_d  = S_MAC;
        end else begin
          state_d = S_RD_X;
        end
      end
      S_MAC: begin
        if (k_q < k_len_q) begin
          state_d    = S_RD_X;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = word_addr(in_addr_q, ik_s);
        end else begin
          state_d = S_ACC_WAIT;
        end
      end
      S_ACC_WAIT: begin
        // Accumulator has absorbed the last product by now
        mem_wdata_d = mac_acc_i;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = word_addr(out_addr_q, i_q);
        state_d     = S_WR_Y;
      end
      S_WR_Y: begin
        if (rsp_s) begin
          wait_d   = 1'b0;
          mem_we_d = 1'b0;
          i_d      = i_inc_s;
          if (i_inc_s < m_q) begin
            state_d   = S_CLR;
            mac_clr_d = 1'b1;
            k_d       = IW'(0);
          end else begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            done_int_d = 1'b1;
          end
        end else begin
          state_d = S_WR_Y;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      in_addr_q   <= 32'd0;
      w_addr_q    <= 32'd0;
      out_addr_q  <= 32'd0;
      k_len_q     <= IW'(0);
      m_q         <= IW'(0);
      i_q         <= IW'(0);
      k_q         <= IW'(0);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      done_int_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= {DATA_W{1'b0}};
      wait_q      <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_x_q     <= {DATA_W{1'b0}};
      mac_w_q     <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      in_addr_q   <= in_addr_d;
      w_addr_q    <= w_addr_d;
      out_addr_q  <= out_addr_d;
      k_len_q     <= k_len_d;
      m_q         <= m_d;
      i_q         <= i_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      done_int_q  <= done_int_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wait_q      <= wait_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      mac_x_q     <= mac_x_d;
      mac_w_q     <= mac_w_d;
    end
  end

  // Tap buffer needs no reset
  always_ff @(posedge clk_i) begin
    tap_q <= tap_d;
  end

`ifdef CONV1D_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating busy-cycle counter, cleared on every accepted start
  always_comb begin
    if ((state_q == S_IDLE) && start_i) begin
      perf_d = 32'd0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Performance counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 32'd0;
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign done_int_o  = done_int_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mac_clr_o   = mac_clr_q;
  assign mac_en_o    = mac_en_q;
  assign mac_x_o     = mac_x_q;
  assign mac_w_o     = mac_w_q;

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Self-checking bench for conv1d_ctrl: memory responder, MAC model and a plain-arithmetic convolution reference.
module tb_conv1d_ctrl;

  localparam int MAX_K  = 8;
  localparam int LEN_W  = 16;
  localparam int DATA_W = 32;
  localparam int KW     = $clog2(MAX_K + 1);
  localparam logic [31:0] IN_BASE  = 32'h0000_1000;
  localparam logic [31:0] W_BASE   = 32'h0000_2000;
  localparam logic [31:0] OUT_BASE = 32'h0000_3000;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [31:0]       in_addr_i = 32'd0, w_addr_i = 32'd0, out_addr_i = 32'd0;
  logic [LEN_W-1:0]  in_len_i = '0;
  logic [KW-1:0]     k_len_i = '0;
  logic              busy_o, done_o, err_o, done_int_o;
  logic              mem_req_o, mem_we_o;
  logic              mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0]       mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mac_clr_o, mac_en_o;
  logic [DATA_W-1:0] mac_x_o, mac_w_o;
  logic [DATA_W-1:0] mac_acc_i = '0;
  logic [31:0]       perf_cycles_o;

  conv1d_ctrl #(.MAX_K(MAX_K), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .in_addr_i(in_addr_i), .w_addr_i(w_addr_i), .out_addr_i(out_addr_i),
    .in_len_i(in_len_i), .k_len_i(k_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .done_int_o(done_int_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mac_clr_o(mac_clr_o), .mac_en_o(mac_en_o), .mac_x_o(mac_x_o), .mac_w_o(mac_w_o),
    .mac_acc_i(mac_acc_i), .perf_cycles_o(perf_cycles_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory, responder knobs and event counters
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int gnt_delay = 0, lat_max = 0;
  int stall_cnt = 0, resp_cnt = 0;
  bit resp_pending = 1'b0;
  logic [31:0] resp_data = 32'd0;
  logic [31:0] sv_addr = 32'd0, sv_wdata = 32'd0;
  logic sv_we = 1'b0;
  int clr_cnt = 0, en_cnt = 0, int_cnt = 0, req_cycles = 0, rd_cnt = 0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  // Memory slave: grants after gnt_delay stall cycles, answers 1+random cycles after grant
  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    if (rst_i) begin
      resp_pending = 1'b0;
      stall_cnt    = 0;
    end else begin
      if (mem_req_o) req_cycles++;
      if (mac_clr_o) clr_cnt++;
      if (mac_en_o) en_cnt++;
      if (done_int_o) int_cnt++;
      if (mac_clr_o || mac_en_o) check("mac_clr_en_exclusive", 32'(mac_clr_o && mac_en_o), 32'd0);
      if (resp_pending) begin
        if (resp_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = resp_data;
          resp_pending = 1'b0;
        end else begin
          resp_cnt--;
        end
      end else if (mem_req_o) begin
        if (stall_cnt > 0)
          check("stall_stable", 32'((mem_addr_o === sv_addr) && (mem_we_o === sv_we) &&
                                    (mem_wdata_o === sv_wdata)), 32'd1);
        if (stall_cnt < gnt_delay) begin
          stall_cnt++;
          sv_addr  = mem_addr_o;
          sv_we    = mem_we_o;
          sv_wdata = mem_wdata_o;
        end else begin
          mem_gnt_i = 1'b1;
          stall_cnt = 0;
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_wdata_o);
            resp_data = 32'd0;
          end else begin
            resp_data = rd_mem(mem_addr_o);
            rd_cnt++;
          end
          resp_pending = 1'b1;
          resp_cnt     = $urandom_range(lat_max, 0);
        end
      end
    end
  end

  // External accumulator
  always @(posedge clk) begin
    if (rst_i || mac_clr_o) mac_acc_i <= '0;
    else if (mac_en_o) mac_acc_i <= mac_acc_i + mac_x_o * mac_w_o;
  end

  logic [31:0] x_arr [16];
  logic [31:0] w_arr [16];

  task automatic drive_start(input int n, input int k);
    @(negedge clk);
    in_addr_i  = IN_BASE;
    w_addr_i   = W_BASE;
    out_addr_i = OUT_BASE;
    in_len_i   = LEN_W'(n);
    k_len_i    = KW'(k);
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_case(input string tag, input int n, input int k, input int gdel,
                          input int lmax, input bit mid_start);
    int m, c0, e0, i0, r0;
    bit timed_out;
    logic [31:0] y;
    gnt_delay = gdel;
    lat_max   = lmax;
    for (int i = 0; i < n; i++) mem[IN_BASE + 32'(4 * i)] = x_arr[i];
    for (int j = 0; j < k; j++) mem[W_BASE + 32'(4 * j)] = w_arr[j];
    wr_addr_q.delete();
    wr_data_q.delete();
    c0 = clr_cnt; e0 = en_cnt; i0 = int_cnt; r0 = rd_cnt;
    drive_start(n, k);
    check({tag, "_start_flags"}, 32'({busy_o, done_o, err_o}), 32'b100);
    if (mid_start) begin
      repeat (7) @(negedge clk);
      in_len_i   = LEN_W'(2);
      k_len_i    = KW'(1);
      in_addr_i  = 32'h0000_5000;
      out_addr_i = 32'h0000_6000;
      start_i    = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    timed_out = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (!busy_o) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    m = n - k + 1;
    check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(m));
    for (int i = 0; i < m; i++) begin
      y = 32'd0;
      for (int j = 0; j < k; j++) y = y + x_arr[i + j] * w_arr[j];
      if (i < wr_addr_q.size()) begin
        check({tag, "_y_addr"}, wr_addr_q[i], OUT_BASE + 32'(4 * i));
        check({tag, "_y_data"}, wr_data_q[i], y);
      end
    end
    check({tag, "_end_flags"}, 32'({busy_o, done_o, err_o}), 32'b010);
    check({tag, "_int_pulses"}, 32'(int_cnt - i0), 32'd1);
    check({tag, "_clr_pulses"}, 32'(clr_cnt - c0), 32'(m));
    check({tag, "_en_pulses"}, 32'(en_cnt - e0), 32'(m * k));
    check({tag, "_reads"}, 32'(rd_cnt - r0), 32'(k + m * k));
  endtask

  task automatic run_err(input string tag, input int n, input int k);
    int i0, q0;
    i0 = int_cnt; q0 = req_cycles;
    drive_start(n, k);
    check({tag, "_flags"}, 32'({busy_o, done_o, err_o}), 32'b011);
    repeat (4) @(negedge clk);
    check({tag, "_int_pulses"}, 32'(int_cnt - i0), 32'd1);
    check({tag, "_req_cycles"}, 32'(req_cycles - q0), 32'd0);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 5; i++) x_arr[i] = 32'(i + 1);
    for (int j = 0; j < 3; j++) w_arr[j] = 32'd1;
  endtask

  logic [31:0] perf_base, perf_stall;
  bit found;
  int i0, nn, kk;

  initial begin
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({busy_o, done_o, err_o, done_int_o, mem_req_o, mem_we_o,
                                mac_clr_o, mac_en_o}), 32'd0);
    check("reset_addr", mem_addr_o, 32'd0);
    check("reset_perf", perf_cycles_o, 32'd0);

    load_basic();
    run_case("basic", 5, 3, 0, 0, 1'b0);
    perf_base = perf_cycles_o;
    run_case("stall", 5, 3, 4, 0, 1'b0);
    perf_stall = perf_cycles_o;
`ifdef CONV1D_CTRL_PERF_EN
    check("perf_stall_delta", perf_stall - perf_base, 32'd60);
`else
    check("perf_tied_zero", perf_stall | perf_base, 32'd0);
`endif

    run_err("err_k0", 5, 0);
    run_err("err_kmax", 12, MAX_K + 1);
    run_err("err_n_lt_k", 2, 3);

    run_case("mid_start", 5, 3, 1, 1, 1'b1);

    // Reset while a sample read is outstanding
    gnt_delay = 2;
    lat_max   = 0;
    drive_start(5, 3);
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (mem_req_o && (mem_addr_o >= IN_BASE) && (mem_addr_o < IN_BASE + 32'd64)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reach_rd_x", 32'(found), 32'd1);
    i0 = int_cnt;
    rst_i = 1'b1;
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_no_int", 32'(int_cnt - i0), 32'd0);
    check("rst_mid_no_done", 32'(done_o), 32'd0);
    run_case("after_rst", 5, 3, 0, 0, 1'b0);

    x_arr[0] = 32'hFFFF_FFFF;
    w_arr[0] = 32'd2;
    run_case("wrap", 1, 1, 0, 0, 1'b0);
    repeat (10) @(negedge clk);
    check("done_sticky", 32'(done_o), 32'd1);

    for (int r = 0; r < 4; r++) begin
      nn = $urandom_range(12, 1);
      kk = $urandom_range((nn < MAX_K) ? nn : MAX_K, 1);
      for (int i = 0; i < nn; i++) x_arr[i] = $urandom;
      for (int j = 0; j < kk; j++) w_arr[j] = $urandom;
      run_case("random", nn, kk, $urandom_range(2, 0), $urandom_range(2, 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv1d_ctrl.md
Name: conv1d_ctrl

Overview:
Sequencer for the conv1d accelerator datapath. On a start command it fetches the kernel taps into a local buffer, then walks the input window by window over a single-outstanding memory master port. It feeds sample/tap pairs to an external MAC and writes each accumulated result back to memory. It sits between the control-register block (start/config/status) and the accelerator's memory port and MAC, and raises the completion interrupt.

Parameters:
MAX_K, 8, maximum kernel taps held in the local tap buffer (>=1)
LEN_W, 16, width of the input-length field
DATA_W, 32, sample/tap/result and memory data width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start pulse from control registers
in_addr_i  in  32  byte base address of x[]
w_addr_i  in  32  byte base address of w[]
out_addr_i  in  32  byte base address of y[]
in_len_i  in  LEN_W  number of input samples N
k_len_i  in  $clog2(MAX_K+1)  number of taps K
busy_o  out  1  operation in progress
done_o  out  1  sticky done, cleared by accepted start
err_o  out  1  sticky config error, cleared by accepted start
done_int_o  out  1  one-cycle completion interrupt pulse
mem_req_o  out  1  memory request
mem_gnt_i  in  1  request granted
mem_we_o  out  1  1 = write
mem_addr_o  out  32  byte address, word aligned
mem_wdata_o  out  DATA_W  write data
mem_rvalid_i  in  1  response valid (reads and writes)
mem_rdata_i  in  DATA_W  read data
mac_clr_o  out  1  clear accumulator
mac_en_o  out  1  accumulate mac_x_o*mac_w_o
mac_x_o  out  DATA_W  sample operand
mac_w_o  out  DATA_W  tap operand
mac_acc_i  in  DATA_W  accumulator value, updated the cycle after mac_en_o
perf_cycles_o  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset (sync, rst_i=1 at a clk_i edge): state IDLE; every output 0; tap buffer contents don't-care. Reset mid-operation aborts immediately, mem_req_o drops next cycle, no done/interrupt.
- start_i accepted only in IDLE; ignored while busy_o=1. On accept: latch all cfg inputs, clear done_o/err_o, busy_o=1 from the next cycle.
- Config check on accept: K==0, K>MAX_K, or N<K -> err_o=1, done_o=1, done_int_o pulse the next cycle, no memory traffic, back to IDLE.
- Output count M = N-K+1 (valid mode). y[i] = sum_{k<K} x[i+k]*w[k], with wrap-around modulo 2^DATA_W done by the MAC.
- Memory handshake: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable until mem_gnt_i=1. mem_req_o is deasserted in the cycle after grant. The controller waits for mem_rvalid_i (>=1 cycle after grant) before issuing the next request. At most one outstanding transaction. Addresses = base + 4*index.
- FSM:
  IDLE -> LOAD_W (K read transactions from w_addr_i; tap k stored on rvalid).
  LOAD_W -> CLR: mac_clr_o=1 for one cycle, i and k set to 0.
  CLR -> RD_X: read x[i+k].
  RD_X -> MAC on rvalid: mac_en_o=1 for one cycle, mac_x_o=rdata, mac_w_o=tap[k]; k++.
  MAC -> RD_X if k<K, else ACC_WAIT.
  ACC_WAIT: one cycle for mac_acc_i to settle.
  ACC_WAIT -> WR_Y: write mac_acc_i to y[i]; the value is captured in ACC_WAIT.
  WR_Y, on rvalid: i++. If i<M -> CLR, else -> DONE.
  DONE: done_o=1, done_int_o=1 for exactly one cycle, busy_o=0 next cycle, -> IDLE.
- mac_clr_o and mac_en_o are never asserted in the same cycle. Outside CLR/MAC both are 0.
- Index counters are LEN_W+1 bits wide, so i+k never overflows.

Optional Feature:
CONV1D_CTRL_PERF_EN
- Defined: a 32-bit counter clears on accepted start, increments every cycle busy_o=1, saturates at 2^32-1, and holds its value after done; driven on perf_cycles_o.
- Not defined: perf_cycles_o tied to 0, no counter flops.

Test Plan:
- N=5, K=3, x=1..5, w=1,1,1, mem gnt same cycle, rvalid +1 -> 3 reads of w, then y=6,9,12 written to out_addr+0/4/8; 3 mac_clr_o pulses; 9 mac_en_o pulses; one done_int_o pulse.
- Same config with mem_gnt_i held low 4 cycles on every request -> address and data stable throughout the stall; identical results; perf_cycles_o grows by 4 per request when the macro is defined.
- K=0, then K=MAX_K+1, then N=2,K=3 -> err_o=1, done_int_o pulse, zero mem_req_o cycles in each case.
- start_i pulsed again mid-run -> ignored; cfg changes mid-run have no effect; results still 6,9,12.
- rst_i asserted during RD_X -> next cycle mem_req_o=0, busy_o=0, no done_int_o; a fresh start then completes correctly.
- N=1, K=1, x=0xFFFFFFFF, w=2 -> single write y[0]=0xFFFFFFFE (wrap), done_o sticky until the next start.
